data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 22 ++
 rtl/data_memory_responder.sv | 115 +++++++++++
 tb/tb_data_memory_responder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Block-transfer memory bus between a cache controller (master) and the data memory (slave).
interface data_memory_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BLOCK_BITS = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [BLOCK_BITS-1:0] writedata;
    logic [BLOCK_BITS-1:0] readdata;
    logic                  busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/data_memory_responder.sv
// Block data memory answering cache miss/write-back requests after a fixed latency,
// with a busywait handshake (IDLE -> BUSY -> DONE -> IDLE).
module data_memory_responder #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned BLOCK_BITS   = 128,
    parameter int unsigned DEPTH_BLOCKS = 256,
    parameter int unsigned LATENCY      = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_BLOCKS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [BLOCK_BITS-1:0] mem [DEPTH_BLOCKS];
    logic [BLOCK_BITS-1:0] readdata_q;
    logic [BLOCK_BITS-1:0] wdata_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  is_read_q;
    logic [CNT_W-1:0]      count_q;

    logic             valid;
    logic             busy;
    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    // Offset bits and bits above the block index do not select storage: addresses wrap.
    assign idx         = bus.address[IDX_W+3:4];
    assign unused_addr = ^{bus.address[3:0], bus.address[ADDR_WIDTH-1:IDX_W+4]};
    assign valid       = bus.read ^ bus.write;

    assign bus.readdata = readdata_q;
    assign bus.busywait = busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = valid;
                if (valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_BLOCKS; i++) begin
                mem[i] <= '0;
            end
            readdata_q <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            is_read_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        idx_q     <= idx;
                        is_read_q <= bus.read;
                        wdata_q   <= bus.writedata;
                        count_q   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    // Only captured request fields are used; live inputs are ignored here.
                    if (count_q == '0) begin
                        if (is_read_q) begin
                            readdata_q <= mem[idx_q];
                        end else begin
                            mem[idx_q] <= wdata_q;
                        end
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: the driver pushes expected readdata per access, a negedge monitor
// checks busywait length and readdata at every completion.
module tb_data_memory_responder;
    localparam int unsigned LAT  = 5;
    localparam int unsigned NBLK = 256;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        bit           is_rd;
        logic [127:0] exp_rd;
    } sb_t;

    sb_t          sb [$];
    sb_t          mon_e;
    int           run = 0;
    logic [127:0] ref_mem [NBLK];
    logic [127:0] ref_rd;

    data_memory_responder_if #(.ADDR_WIDTH(32), .BLOCK_BITS(128)) bus ();

    data_memory_responder #(
        .ADDR_WIDTH  (32),
        .BLOCK_BITS  (128),
        .DEPTH_BLOCKS(NBLK),
        .LATENCY     (LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic int unsigned blk(input logic [31:0] a);
        return (a / 16) % NBLK;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < int'(NBLK); i++) ref_mem[i] = '0;
        ref_rd = '0;
    endtask

    task automatic issue(input bit is_rd, input logic [31:0] a, input logic [127:0] d);
        bus.read      = is_rd;
        bus.write     = !is_rd;
        bus.address   = a;
        bus.writedata = d;
        if (is_rd) ref_rd = ref_mem[blk(a)];
        else       ref_mem[blk(a)] = d;
        sb.push_back('{is_rd, ref_rd});
    endtask

    // Counts negedges from the request cycle up to and including the first busywait-low cycle.
    task automatic wait_done(input bit scramble, output int n);
        bit fin;
        n   = 0;
        fin = 0;
        while (!fin) begin
            @(negedge clock);
            n++;
            if (!bus.busywait) begin
                fin = 1;
            end else if (n >= int'(4 * LAT + 20)) begin
                total++;
                bad++;
                $display("FAIL timeout: busywait high for %0d cycles, expected %0d", n, LAT + 1);
                fin = 1;
            end else if (scramble && n >= 2) begin
                #1;
                bus.address   = $urandom;
                bus.writedata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic access(input bit is_rd, input logic [31:0] a, input logic [127:0] d,
                          input bit scramble);
        int n;
        @(posedge clock);
        #1;
        issue(is_rd, a, d);
        wait_done(scramble, n);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        check("access_cycles", 128'(n), 128'(LAT + 2));
    endtask

    always @(negedge clock) begin
        if (reset) begin
            run = 0;
        end else if (bus.busywait) begin
            run++;
        end else if (run > 0) begin
            check("busy_len", 128'(run), 128'(LAT + 1));
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_completion: got completion expected none");
            end else begin
                mon_e = sb.pop_front();
                check(mon_e.is_rd ? "read_data" : "write_keeps_readdata", bus.readdata, mon_e.exp_rd);
            end
            run = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic [31:0]  ra;
        logic [127:0] blk_a, blk_b, blk_c;

        reset         = 1'b1;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        ref_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_busywait", 128'(bus.busywait), 128'(0));
        check("reset_readdata", bus.readdata, '0);

        access(1, 32'h0000_0040, '0, 0);

        access(0, 32'h0000_0120, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0);
        access(1, 32'h0000_012C, '0, 0);

        blk_a = {$urandom, $urandom, $urandom, $urandom};
        blk_b = {$urandom, $urandom, $urandom, $urandom};
        access(0, 32'h0000_0010, blk_a, 0);
        access(0, 32'h0000_1010, blk_b, 0);
        access(1, 32'h0000_0010, '0, 0);

        blk_c = {$urandom, $urandom, $urandom, $urandom};
        access(0, 32'h0000_0030, blk_c, 1);
        access(1, 32'h0000_0030, '0, 0);
        access(1, 32'h0000_0020, '0, 0);
        access(1, 32'h0000_0040, '0, 0);
        access(1, 32'h0000_0010, '0, 0);

        // read and write together are not a request
        @(posedge clock);
        #1;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        bus.address   = 32'h0000_0120;
        bus.writedata = '1;
        repeat (4) begin
            @(negedge clock);
            check("both_high_busywait", 128'(bus.busywait), 128'(0));
            check("both_high_readdata", bus.readdata, ref_rd);
        end
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        access(1, 32'h0000_0120, '0, 0);

        // read held through DONE starts a second access in the following cycle
        @(posedge clock);
        #1;
        issue(1, 32'h0000_0124, '0);
        wait_done(0, n);
        check("hold_first_cycles", 128'(n), 128'(LAT + 2));
        issue(1, 32'h0000_0124, '0);
        wait_done(0, n);
        check("hold_second_cycles", 128'(n), 128'(LAT + 2));
        #1 bus.read = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ra        = $urandom;
            ra[11:4]  = 8'($urandom_range(0, 15));
            access(1'($urandom_range(0, 1)), ra, {$urandom, $urandom, $urandom, $urandom}, 0);
        end

        // reset on the third BUSY cycle of a write aborts it and clears everything
        @(posedge clock);
        #1;
        bus.read      = 1'b0;
        bus.write     = 1'b1;
        bus.address   = 32'h0000_0050;
        bus.writedata = '1;
        repeat (3) @(posedge clock);
        #1;
        reset     = 1'b1;
        bus.write = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        ref_reset();
        @(negedge clock);
        check("abort_busywait", 128'(bus.busywait), 128'(0));
        check("abort_readdata", bus.readdata, '0);
        access(1, 32'h0000_0050, '0, 0);
        access(1, 32'h0000_0120, '0, 0);
        access(1, 32'h0000_0010, '0, 0);

        repeat (3) @(posedge clock);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
